// File: rtl/linkspeed_tx_gen.sv
// MBTRAIN.LINKSPEED transmit-side sequencer: start handshake, point test with bounded retry,
// per-group grading, then DONE / ERROR->REPAIR|DEGRADE / PHYRETRAIN exit with an encoded result.
module linkspeed_tx_gen #(
  parameter int unsigned NUM_LANES  = 16,
  parameter int unsigned NUM_GROUPS = 2,
  parameter int unsigned MAX_RETRY  = 2,
  parameter int unsigned TMO_W      = 20,
  parameter int unsigned TMO_CYC    = 800000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [3:0]            i_sb_msg,
  input  logic                  i_sb_valid,
  input  logic                  i_pt_ack,
  input  logic [NUM_LANES-1:0]  i_lanes_result,
  input  logic                  i_valid_framing_error,
  input  logic                  i_from_repair,
  input  logic [NUM_GROUPS-1:0] i_prev_group_mask,
  output logic [3:0]            o_sb_msg,
  output logic                  o_sb_valid,
  output logic                  o_pt_en,
  output logic                  o_test_ack,
  output logic                  o_timeout,
  output logic [NUM_GROUPS-1:0] o_group_mask,
  output logic [2:0]            o_exit_code,
  output logic [2:0]            o_retry_cnt
);

  localparam int unsigned GL = NUM_LANES / NUM_GROUPS;

  localparam logic [3:0] MsgStartReq    = 4'd1;
  localparam logic [3:0] MsgStartResp   = 4'd2;
  localparam logic [3:0] MsgErrorReq    = 4'd3;
  localparam logic [3:0] MsgErrorResp   = 4'd4;
  localparam logic [3:0] MsgRepairReq   = 4'd5;
  localparam logic [3:0] MsgRepairResp  = 4'd6;
  localparam logic [3:0] MsgDegradeReq  = 4'd7;
  localparam logic [3:0] MsgDegradeResp = 4'd8;
  localparam logic [3:0] MsgDoneReq     = 4'd9;
  localparam logic [3:0] MsgDoneResp    = 4'd10;
  localparam logic [3:0] MsgPhyReq      = 4'd11;
  localparam logic [3:0] MsgPhyResp     = 4'd12;

  localparam logic [2:0] ExitNone    = 3'd0;
  localparam logic [2:0] ExitDone    = 3'd1;
  localparam logic [2:0] ExitPhy     = 3'd2;
  localparam logic [2:0] ExitRepair  = 3'd3;
  localparam logic [2:0] ExitDegrade = 3'd4;
  localparam logic [2:0] ExitTimeout = 3'd5;

  localparam logic [2:0]       MaxRetry = 3'(MAX_RETRY);
  localparam logic [TMO_W-1:0] TmoLast  = TMO_W'(TMO_CYC - 1);

  typedef enum logic [3:0] {
    StIdle,
    StStartReq,
    StPt,
    StAnalyse,
    StDoneReq,
    StPhyReq,
    StErrorReq,
    StRepairReq,
    StDegradeReq,
    StFin
  } state_e;

  // Code transmitted while parked in a request state; zero for every other state.
  function automatic logic [3:0] req_code(input state_e s);
    case (s)
      StStartReq:   req_code = MsgStartReq;
      StDoneReq:    req_code = MsgDoneReq;
      StPhyReq:     req_code = MsgPhyReq;
      StErrorReq:   req_code = MsgErrorReq;
      StRepairReq:  req_code = MsgRepairReq;
      StDegradeReq: req_code = MsgDegradeReq;
      default:      req_code = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] rsp_code(input state_e s);
    case (s)
      StStartReq:   rsp_code = MsgStartResp;
      StDoneReq:    rsp_code = MsgDoneResp;
      StPhyReq:     rsp_code = MsgPhyResp;
      StErrorReq:   rsp_code = MsgErrorResp;
      StRepairReq:  rsp_code = MsgRepairResp;
      StDegradeReq: rsp_code = MsgDegradeResp;
      default:      rsp_code = 4'd0;
    endcase
  endfunction

  state_e                state_q, state_d;
  logic [TMO_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            retry_q, retry_d;
  logic [NUM_GROUPS-1:0] mask_q, mask_d;
  logic                  fe_q, fe_d;
  logic [2:0]            exit_q, exit_d;
  logic                  tmo_q, tmo_d;
  logic                  sb_valid_q, sb_valid_d;

  logic [NUM_GROUPS-1:0] mask_calc;
  logic                  in_req;
  logic                  counting;
  logic                  rsp_hit;
  logic                  partner_phy;
  logic                  tmo_hit;
  logic                  pt_done;

  always_comb begin
    mask_calc = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      mask_calc[g] = &i_lanes_result[g*GL +: GL];
    end
  end

  always_comb begin
    in_req      = (req_code(state_q) != 4'd0);
    counting    = in_req || (state_q == StPt);
    rsp_hit     = in_req && i_sb_valid && (i_sb_msg == rsp_code(state_q));
    partner_phy = in_req && i_sb_valid && (i_sb_msg == MsgPhyReq);
    pt_done     = (state_q == StPt) && i_pt_ack;
    tmo_hit     = counting && (cnt_q == TmoLast);
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    mask_d  = mask_q;
    fe_d    = fe_q;
    exit_d  = exit_q;
    tmo_d   = tmo_q;

    if (!i_en) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StStartReq;
          retry_d = '0;
          mask_d  = '0;
          fe_d    = 1'b0;
          exit_d  = ExitNone;
          tmo_d   = 1'b0;
        end
        StStartReq: if (rsp_hit) state_d = StPt;
        StPt: begin
          if (i_pt_ack) begin
            state_d = StAnalyse;
            mask_d  = mask_calc;
            fe_d    = i_valid_framing_error;
          end
        end
        StAnalyse: begin
          if (fe_q && (retry_q < MaxRetry)) begin
            state_d = StPt;
            retry_d = retry_q + 3'd1;
          end else if (fe_q) begin
            state_d = StPhyReq;
          end else if (i_from_repair && |(mask_q & i_prev_group_mask)) begin
            state_d = StDoneReq;
          end else if (&mask_q) begin
            state_d = StDoneReq;
          end else begin
            state_d = StErrorReq;
          end
        end
        StDoneReq: begin
          if (rsp_hit) begin
            state_d = StFin;
            exit_d  = ExitDone;
          end
        end
        StPhyReq: begin
          if (rsp_hit) begin
            state_d = StFin;
            exit_d  = ExitPhy;
          end
        end
        StErrorReq: begin
          if (rsp_hit) state_d = (|mask_q) ? StRepairReq : StDegradeReq;
        end
        StRepairReq: begin
          if (rsp_hit) begin
            state_d = StFin;
            exit_d  = ExitRepair;
          end
        end
        StDegradeReq: begin
          if (rsp_hit) begin
            state_d = StFin;
            exit_d  = ExitDegrade;
          end
        end
        StFin:   state_d = StFin;
        default: state_d = StIdle;
      endcase

      // A partner phyretrain request beats both a matching response and the timeout.
      if (partner_phy) begin
        state_d = StFin;
        exit_d  = ExitPhy;
      end else if (tmo_hit && !rsp_hit && !pt_done) begin
        state_d = StFin;
        exit_d  = ExitTimeout;
        tmo_d   = 1'b1;
      end
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (counting && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    sb_valid_d = (state_d != state_q) && (req_code(state_d) != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      retry_q    <= '0;
      mask_q     <= '0;
      fe_q       <= 1'b0;
      exit_q     <= ExitNone;
      tmo_q      <= 1'b0;
      sb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      mask_q     <= mask_d;
      fe_q       <= fe_d;
      exit_q     <= exit_d;
      tmo_q      <= tmo_d;
      sb_valid_q <= sb_valid_d;
    end
  end

  assign o_sb_msg     = req_code(state_q);
  assign o_sb_valid   = sb_valid_q;
  assign o_pt_en      = (state_q == StPt);
  assign o_test_ack   = (state_q == StFin);
  assign o_timeout    = tmo_q;
  assign o_group_mask = mask_q;
  assign o_exit_code  = exit_q;
  assign o_retry_cnt  = retry_q;

endmodule
